mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- M-stage load/store unit sitting directly upstream of data memory; replaces the zero-latency internal RAM access with a req/ack data bus of variable latency.
- Takes the M-stage access (address, store data, Width, LoadSign) and produces a word-aligned bus request with byte enables and lane-replicated write data.
- Stalls the pipeline until the access completes and returns the load result already extended.
- Flags misaligned and out-of-range addresses and bus timeouts to the exception logic.

Parameters:
- ADDR_LIMIT, 32'h0000_3000, first illegal byte address; any access at or above it is an address exception.
- TIMEOUT, 16, REQ-state cycles without bus_ack before a bus error is declared.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_valid  in  1  M stage holds a load or store
- m_we  in  1  1 = store, 0 = load
- m_addr  in  32  byte address
- m_wdata  in  32  store data, right-justified
- m_width  in  2  0 word, 1 half, 2 byte; 3 is illegal
- m_load_sign  in  1  1 = sign-extend load, 0 = zero-extend
- m_pc  in  32  PC of the access, forwarded to the bus for trace
- m_advance  in  1  pipeline moves M to W at this edge
- m_stall  out  1  M stage must hold
- m_rdata  out  32  extended load data, valid in DONE
- m_exc_adel  out  1  load address exception
- m_exc_ades  out  1  store address exception
- m_bus_err  out  1  access timed out, valid in DONE
- bus_req  out  1  request valid, registered
- bus_we  out  1  write request
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_byteen  out  4  byte lanes written
- bus_wdata  out  32  lane-replicated write data
- bus_pc  out  32  latched m_pc
- bus_ack  in  1  completion; sampled at posedge while bus_req = 1
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (sync, active-high):
  - state returns to IDLE; timeout counter = 0.
  - All registered outputs are 0: bus_req, bus_we, bus_addr, bus_byteen, bus_wdata, bus_pc, m_rdata, m_bus_err.
  - Reset in REQ or DONE abandons the access; bus_req is 0 after that edge.
- Exception detect (combinational; qualified by m_valid, and forced to 0 unless state == IDLE):
  - misaligned: word with addr[1:0] != 0, or half with addr[0] != 0.
  - illegal width: m_width == 3.
  - out of range: addr >= ADDR_LIMIT.
  - Asserts m_exc_ades if m_we = 1, otherwise m_exc_adel.
  - An excepting access issues no request and does not stall.
- Lane formatting:
  - word: byteen 1111, wdata = wd.
  - half: byteen 0011 if addr[1] = 0, 1100 if addr[1] = 1; wdata = {2{wd[15:0]}}.
  - byte: byteen = 0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - Loads drive byteen 0000.
- State IDLE:
  - Condition: m_valid and no exception.
  - Action: latch the payload into the bus registers, set bus_req, reset the counter, go to REQ.
  - m_stall = 1 in this cycle.
- State REQ:
  - m_stall = 1; the payload is held stable; m_* inputs are ignored.
  - On bus_ack: bus_req <- 0; m_rdata <- extend(bus_rdata); m_bus_err <- 0; go to DONE.
  - Extend: select the half by addr[1] or the byte by addr[1:0], then sign- or zero-extend per m_load_sign. A word load passes through unchanged. A store leaves m_rdata = 0.
  - If no ack and counter == TIMEOUT-1: bus_req <- 0; m_bus_err <- 1; m_rdata <- 0; go to DONE.
  - Otherwise the counter increments by 1.
- State DONE:
  - m_stall = 0.
  - m_rdata and m_bus_err hold until m_advance.
  - On m_advance go to IDLE.
  - Without m_advance, stay in DONE; never reissue.
- Minimum penalty, ack in the first REQ cycle: stall in the IDLE and REQ cycles, result in DONE on the third cycle.
- bus_ack while bus_req = 0 is ignored.
- Only one access is ever outstanding.

Decomposition:
- Shared package holds:
  - Width encodings: WIDTH_W = 0, WIDTH_H = 1, WIDTH_B = 2.
  - FSM state encodings: IDLE, REQ, DONE.
  - ADDR_LIMIT default.
- One sub-module, mem_lsu_fmt: purely combinational byteen, wdata replication and load extension, reused by the W-stage checker.
- FSM, counter and registers stay in mem_lsu.

Test Plan:
- sw addr 0x10, wd 0x1234_5678, ack on the 2nd REQ cycle -> bus_addr 0x10, byteen 1111, wdata 0x1234_5678; m_stall high 3 cycles; DONE with m_bus_err 0.
- sb addr 0x13, wd 0x0000_00AB -> byteen 1000, wdata 0xABAB_ABAB, bus_addr 0x10.
- bus_rdata 0x8001_7FFF, ack immediate:
  - lh addr 0x22, sign = 1 -> m_rdata 0xFFFF_8001.
  - lh addr 0x22, sign = 0 -> m_rdata 0x0000_8001.
  - lb addr 0x21, sign = 1 -> m_rdata 0x0000_007F.
- Address exceptions, none issuing a request and none stalling:
  - lw addr 0x6 -> m_exc_adel 1, bus_req never 1, m_stall 0.
  - sh addr 0x3000 -> m_exc_ades 1, bus_req never 1, m_stall 0.
- Load with no ack, TIMEOUT = 16 -> bus_req drops after 16 REQ cycles; m_bus_err 1, m_rdata 0.
- Reset and DONE hold:
  - reset asserted during REQ -> bus_req 0 at the next edge; next m_valid restarts from IDLE.
  - DONE held with m_advance = 0 for 3 cycles -> no new bus_req; m_rdata stable.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and payload types for the M-stage load/store unit.
package mem_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] WIDTH_W = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_B = 2'd2;
    localparam logic [1:0] WIDTH_X = 2'd3;

    localparam logic [DATA_W-1:0] ADDR_LIMIT_DEF = 32'h0000_3000;
    localparam int unsigned       TIMEOUT_DEF    = 16;
    localparam int unsigned       CNT_W_DEF      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [BE_W-1:0]   byteen;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pc;
    } bus_payload_t;

    // Access attributes still needed once the request is on the bus.
    typedef struct packed {
        logic [1:0] width;
        logic [1:0] addr_lo;
        logic       load_sign;
    } ext_ctx_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Word-aligned req/ack data bus between the LSU and data memory.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [BE_W-1:0]   bus_byteen;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_pc;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata, bus_pc,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata, bus_pc,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_lsu_fmt.sv
// Combinational lane formatting: store byte enables, write-data replication
// and load extraction/extension. Shared with the W-stage checker.
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  logic              we,
    input  logic [1:0]        width,
    input  logic [1:0]        addr_lo,
    input  logic              load_sign,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   byteen,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        byteen    = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];

        case (width)
            WIDTH_H: begin
                byteen    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{load_sign & half_sel[15]}}, half_sel};
            end
            WIDTH_B: begin
                byteen    = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{load_sign & byte_sel[7]}}, byte_sel};
            end
            default: ;
        endcase

        if (!we) begin
            byteen = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// M-stage load/store unit: issues one req/ack bus access at a time, stalls
// the pipeline until it completes and reports address and timeout errors.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m_valid,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [1:0]  m_width,
    input  logic        m_load_sign,
    input  logic [31:0] m_pc,
    input  logic        m_advance,
    output logic        m_stall,
    output logic [31:0] m_rdata,
    output logic        m_exc_adel,
    output logic        m_exc_ades,
    output logic        m_bus_err,

    mem_lsu_if.master   bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    bus_payload_t        pay_q, pay_d;
    ext_ctx_t            ctx_q, ctx_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                exc;
    logic                misaligned;
    logic                issue_sel;
    logic [BE_W-1:0]     fmt_byteen;
    logic [DATA_W-1:0]   fmt_wdata;
    logic [DATA_W-1:0]   fmt_rdata;

    // Exceptions only exist for a fresh access sitting in IDLE.
    assign misaligned = ((m_width == WIDTH_W) && (m_addr[1:0] != 2'b00)) ||
                        ((m_width == WIDTH_H) && m_addr[0]);
    assign exc = m_valid && (state_q == IDLE) &&
                 (misaligned || (m_width == WIDTH_X) || (m_addr >= ADDR_LIMIT));
    assign m_exc_ades = exc && m_we;
    assign m_exc_adel = exc && !m_we;

    // One formatter: fed by the live M-stage access in IDLE, by the latched
    // context while the request is outstanding.
    assign issue_sel = (state_q == IDLE);

    mem_lsu_fmt u_fmt (
        .we        (issue_sel ? m_we        : pay_q.we),
        .width     (issue_sel ? m_width     : ctx_q.width),
        .addr_lo   (issue_sel ? m_addr[1:0] : ctx_q.addr_lo),
        .load_sign (issue_sel ? m_load_sign : ctx_q.load_sign),
        .wdata     (m_wdata),
        .rdata     (bus.bus_rdata),
        .byteen    (fmt_byteen),
        .wdata_rep (fmt_wdata),
        .rdata_ext (fmt_rdata)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
        ctx_d   = ctx_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        m_stall = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_valid && !exc) begin
                    m_stall           = 1'b1;
                    state_d           = REQ;
                    req_d             = 1'b1;
                    cnt_d             = '0;
                    pay_d.we          = m_we;
                    pay_d.addr        = {m_addr[31:2], 2'b00};
                    pay_d.byteen      = fmt_byteen;
                    pay_d.wdata       = fmt_wdata;
                    pay_d.pc          = m_pc;
                    ctx_d.width       = m_width;
                    ctx_d.addr_lo     = m_addr[1:0];
                    ctx_d.load_sign   = m_load_sign;
                end
            end
            REQ: begin
                m_stall = 1'b1;
                if (bus.bus_ack) begin
                    req_d   = 1'b0;
                    rdata_d = pay_q.we ? '0 : fmt_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (m_advance) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            ctx_q   <= '0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            ctx_q   <= ctx_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.bus_req    = req_q;
    assign bus.bus_we     = pay_q.we;
    assign bus.bus_addr   = pay_q.addr;
    assign bus.bus_byteen = pay_q.byteen;
    assign bus.bus_wdata  = pay_q.wdata;
    assign bus.bus_pc     = pay_q.pc;
    assign m_rdata        = rdata_q;
    assign m_bus_err      = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus randomized accesses checked against
// a byte-level reference model of the access rules.
module tb_mem_lsu;

    localparam int unsigned TO      = 16;
    localparam logic [31:0] A_LIMIT = 32'h0000_3000;
    localparam int          NEVER   = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_we, m_load_sign, m_advance;
    logic [31:0] m_addr, m_wdata, m_pc;
    logic [1:0]  m_width;
    logic        m_stall, m_exc_adel, m_exc_ades, m_bus_err;
    logic [31:0] m_rdata;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    mem_lsu_if bus_if ();

    mem_lsu #(.ADDR_LIMIT(A_LIMIT), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_width     (m_width),
        .m_load_sign (m_load_sign),
        .m_pc        (m_pc),
        .m_advance   (m_advance),
        .m_stall     (m_stall),
        .m_rdata     (m_rdata),
        .m_exc_adel  (m_exc_adel),
        .m_exc_ades  (m_exc_ades),
        .m_bus_err   (m_bus_err),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules, expressed on bytes and offsets.
    function automatic logic model_exc(input logic [1:0] w, input logic [31:0] a);
        int unsigned sz;
        if (w == 2'd3) return 1'b1;
        sz = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
        return ((a % sz) != 0) || (a >= A_LIMIT);
    endfunction

    function automatic logic [3:0] model_byteen(input logic we, input logic [1:0] w, input logic [31:0] a);
        int unsigned sz, mask;
        if (!we) return 4'b0000;
        sz   = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
        mask = ((1 << sz) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] wd);
        if (w == 2'd0) return wd;
        if (w == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return (wd & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] w, input logic [31:0] a,
                                               input logic sign, input logic [31:0] rd);
        logic [31:0] v;
        if (w == 2'd0) return rd;
        v = rd >> (8 * (a % 4));
        if (w == 2'd1) begin
            v = v & 32'hFFFF;
            if (sign && v >= 32'h8000) v = v - 32'h0001_0000;
        end else begin
            v = v & 32'hFF;
            if (sign && v >= 32'h80) v = v - 32'h100;
        end
        return v;
    endfunction

    // One full access: issue, bus response after ack_at REQ cycles (NEVER = no ack),
    // optional DONE hold, then advance.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [1:0] w, input logic sign, input int ack_at,
                             input logic [31:0] rd, input int hold);
        logic [31:0] pc, exp_rd;
        logic        exc, exp_err;
        int          n_req, exp_req;
        bit          done;
        pc  = $urandom;
        exc = model_exc(w, addr);
        @(negedge clk);
        m_valid = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_width = w;
        m_load_sign = sign; m_pc = pc; m_advance = 1'b0;
        #1;
        check("exc_adel", m_exc_adel, exc && !we);
        check("exc_ades", m_exc_ades, exc && we);
        check("stall_issue", m_stall, !exc);
        if (exc) begin
            @(negedge clk);
            check("exc_no_req", bus_if.bus_req, 0);
            check("exc_no_stall", m_stall, 0);
            m_valid = 1'b0;
            return;
        end
        exp_err = (ack_at >= int'(TO));
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(w, addr, sign, rd);
        exp_req = exp_err ? int'(TO) : ack_at + 1;
        n_req = 0;
        done  = 0;
        for (int k = 0; k < int'(TO) + 4 && !done; k++) begin
            @(negedge clk);
            if (!bus_if.bus_req) begin
                done = 1;
            end else begin
                n_req++;
                check("stall_req", m_stall, 1);
                check("exc_in_req", {30'd0, m_exc_adel, m_exc_ades}, 0);
                check("bus_we", bus_if.bus_we, we);
                check("bus_addr", bus_if.bus_addr, addr & 32'hFFFF_FFFC);
                check("bus_byteen", bus_if.bus_byteen, model_byteen(we, w, addr));
                check("bus_pc", bus_if.bus_pc, pc);
                if (we) check("bus_wdata", bus_if.bus_wdata, model_wdata(w, wd));
                bus_if.bus_ack   = (k == ack_at);
                bus_if.bus_rdata = (k == ack_at) ? rd : $urandom;
                m_valid = $urandom; m_we = $urandom; m_addr = $urandom; m_wdata = $urandom;
                m_width = 2'($urandom); m_load_sign = $urandom; m_pc = $urandom;
            end
        end
        check("done_reached", done, 1);
        bus_if.bus_ack = 1'b0;
        m_valid = 1'b1;
        m_advance = 1'b0;
        check("req_cycles", n_req, exp_req);
        check("stall_cycles", n_req + 1, exp_req + 1);
        check("stall_done", m_stall, 0);
        check("rdata", m_rdata, exp_rd);
        check("bus_err", m_bus_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            bus_if.bus_ack   = $urandom;
            bus_if.bus_rdata = $urandom;
            @(negedge clk);
            check("hold_no_req", bus_if.bus_req, 0);
            check("hold_rdata", m_rdata, exp_rd);
            check("hold_err", m_bus_err, exp_err);
            check("hold_stall", m_stall, 0);
        end
        bus_if.bus_ack = 1'b0;
        m_advance = 1'b1;
        @(negedge clk);
        m_advance = 1'b0;
        m_valid   = 1'b0;
        check("idle_no_req", bus_if.bus_req, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  w;
        logic [31:0] a;
        int          ack;
        reset = 1'b1;
        m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_width = '0;
        m_load_sign = 1'b0; m_pc = '0; m_advance = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req", bus_if.bus_req, 0);
        check("rst_we", bus_if.bus_we, 0);
        check("rst_addr", bus_if.bus_addr, 0);
        check("rst_byteen", bus_if.bus_byteen, 0);
        check("rst_wdata", bus_if.bus_wdata, 0);
        check("rst_pc", bus_if.bus_pc, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_err", m_bus_err, 0);
        check("rst_stall", m_stall, 0);
        reset = 1'b0;

        do_access(1'b1, 32'h10, 32'h1234_5678, 2'd0, 1'b0, 1, 32'h0, 0);
        do_access(1'b1, 32'h13, 32'h0000_00AB, 2'd2, 1'b0, 0, 32'h0, 0);
        do_access(1'b0, 32'h22, 32'h0, 2'd1, 1'b1, 0, 32'h8001_7FFF, 0);
        do_access(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0, 32'h8001_7FFF, 0);
        do_access(1'b0, 32'h21, 32'h0, 2'd2, 1'b1, 0, 32'h8001_7FFF, 0);
        do_access(1'b0, 32'h6, 32'h0, 2'd0, 1'b0, 0, 32'h0, 0);
        do_access(1'b1, 32'h3000, 32'h0, 2'd1, 1'b0, 0, 32'h0, 0);
        do_access(1'b0, 32'h40, 32'h0, 2'd0, 1'b0, NEVER, 32'h0, 0);
        do_access(1'b0, 32'h44, 32'h0, 2'd2, 1'b1, int'(TO) - 1, 32'hDEAD_BEEF, 0);
        do_access(1'b0, 32'h2FFC, 32'h0, 2'd0, 1'b0, 2, 32'hCAFE_F00D, 3);
        do_access(1'b1, 32'h2FFF, 32'h5A, 2'd2, 1'b0, 0, 32'h0, 0);

        // Reset while a request is outstanding abandons it.
        @(negedge clk);
        m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h80; m_width = 2'd0; m_pc = 32'h100;
        @(negedge clk);
        check("pre_rst_req", bus_if.bus_req, 1);
        reset = 1'b1; m_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_req", bus_if.bus_req, 0);
        check("mid_rst_stall", m_stall, 0);
        check("mid_rst_err", m_bus_err, 0);
        reset = 1'b0;
        do_access(1'b0, 32'h84, 32'h0, 2'd1, 1'b1, 0, 32'h1234_F00F, 0);

        for (int i = 0; i < 80; i++) begin
            w = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FFF);
            if ($urandom_range(0, 1) == 1) a = a & ((w == 2'd0) ? 32'hFFFF_FFFC :
                                                    (w == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            ack = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
            do_access(1'($urandom), a, $urandom, w, 1'($urandom), ack, $urandom,
                      int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
